sram_qpi_arbiter: RTL and testbench

Shares the single SRAM QPI transaction engine (one QPI bus, 4 chip selects) between NREQ requesters, e.g. host mem-QPI readout, sensor capture writer and flash→SRAM loader. Round-robin arbitration with optional fixed priority for requester 0. Latches the winner's command, sequences one engine transaction and routes the byte streams. A watchdog aborts hung transactions.

---
 rtl/sram_qpi_arbiter.sv | 141 ++++++++++++++
 tb/tb_sram_qpi_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_qpi_arbiter.sv
// Shares one SRAM QPI transaction engine between NREQ requesters: round-robin
// (optionally requester-0 priority) grant, command latch, byte routing, watchdog.
module sram_qpi_arbiter #(
  parameter int NREQ    = 3,
  parameter int ADDR_W  = 26,
  parameter int LEN_W   = 16,
  parameter int FIXED0  = 0,
  parameter int TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_wr,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*LEN_W-1:0] req_len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  input  logic [NREQ*8-1:0]     wr_data,
  input  logic [NREQ-1:0]       wr_valid,
  output logic [NREQ-1:0]       wr_ready,
  output logic [7:0]            rd_data,
  output logic [NREQ-1:0]       rd_valid,
  output logic                  eng_start,
  output logic                  eng_wr,
  output logic [1:0]            eng_cs_sel,
  output logic [23:0]           eng_addr,
  output logic [LEN_W-1:0]      eng_len,
  output logic                  eng_abort,
  output logic [7:0]            eng_wdata,
  output logic                  eng_wvalid,
  input  logic                  eng_wready,
  input  logic [7:0]            eng_rdata,
  input  logic                  eng_rvalid,
  input  logic                  eng_done,
  output logic                  busy,
  output logic [1:0]            owner,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [1:0]      owner_q, rr_q, win;
  logic            found;
  logic [2:0]      scan;
  logic [WD_W-1:0] wd_q;
  logic            err_q;
  logic [NREQ-1:0] own_oh;
  logic            run, zero_len, timeout_hit, grant_now;

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    win   = '0;
    found = 1'b0;
    scan  = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan = {1'b0, rr_q} + 3'(i);
      if (scan >= 3'(NREQ)) scan = scan - 3'(NREQ);
      if (!found && |(req & (NREQ'(1) << scan))) begin
        win   = scan[1:0];
        found = 1'b1;
      end
    end
    if (FIXED0 != 0 && req[0]) win = '0;
  end

  assign run       = (state_q == S_RUN);
  assign grant_now = (state_q == S_IDLE) && |req;
  assign own_oh    = NREQ'(1) << owner_q;
  assign zero_len  = (eng_len == '0);
  // eng_done takes precedence over a timeout landing in the same cycle.
  assign timeout_hit = (TIMEOUT != 0) && (wd_q == WD_LAST) && !eng_done && !zero_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // A zero-length command still gets its one grant cycle, then completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_now) state_d = S_RUN;
      S_RUN:   if (zero_len || eng_done || timeout_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= '0;
      rr_q       <= '0;
      wd_q       <= '0;
      err_q      <= 1'b0;
      eng_wr     <= 1'b0;
      eng_cs_sel <= '0;
      eng_addr   <= '0;
      eng_len    <= '0;
    end else begin
      if (grant_now) begin
        owner_q    <= win;
        eng_wr     <= |(req_wr & (NREQ'(1) << win));
        eng_cs_sel <= req_addr[int'(win)*ADDR_W + 24 +: 2];
        eng_addr   <= req_addr[int'(win)*ADDR_W +: 24];
        eng_len    <= req_len[int'(win)*LEN_W +: LEN_W];
        wd_q       <= '0;
        err_q      <= 1'b0;
      end
      if (run && wd_q != '1) wd_q <= wd_q + 1'b1;
      if (run && state_d == S_DONE) err_q <= timeout_hit;
      if (state_q == S_DONE) rr_q <= (owner_q == 2'(NREQ - 1)) ? 2'd0 : owner_q + 2'd1;
    end
  end

  assign gnt       = run ? own_oh : '0;
  assign done      = (state_q == S_DONE) ? own_oh : '0;
  assign err       = (state_q == S_DONE) && err_q;
  assign eng_start = run && (wd_q == '0) && !zero_len;
  assign eng_abort = run && timeout_hit;
  assign busy      = (state_q != S_IDLE);
  assign owner     = owner_q;
  assign dbg_state = state_q;

  // Byte streams: a byte moves on a cycle where valid and ready are both high;
  // only the owner sees ready/valid, and only while RUN in the latched direction.
  assign eng_wdata  = run ? wr_data[int'(owner_q)*8 +: 8] : '0;
  assign eng_wvalid = run && eng_wr && |(wr_valid & own_oh);
  assign wr_ready   = (run && eng_wr && eng_wready) ? own_oh : '0;
  assign rd_data    = run ? eng_rdata : '0;
  assign rd_valid   = (run && !eng_wr && eng_rvalid) ? own_oh : '0;

endmodule

// File: tb/tb_sram_qpi_arbiter.sv
// Directed bench for sram_qpi_arbiter: round-robin instance (a) plus a
// requester-0 priority instance (b) sharing the same stimulus, TIMEOUT=10.
module tb_sram_qpi_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0, req_wr = '0, wr_valid = '0;
  logic [77:0] req_addr = '0;
  logic [47:0] req_len = '0;
  logic [23:0] wr_data = '0;
  logic        eng_wready = 1'b0, eng_rvalid = 1'b0, eng_done = 1'b0;
  logic [7:0]  eng_rdata = '0;

  logic [2:0]  gnt, done, wr_ready, rd_valid;
  logic        err, eng_start, eng_wr, eng_abort, eng_wvalid, busy;
  logic [7:0]  rd_data, eng_wdata;
  logic [1:0]  eng_cs_sel, owner, dbg_state;
  logic [23:0] eng_addr;
  logic [15:0] eng_len;

  logic [2:0]  b_gnt, b_done, b_wr_ready, b_rd_valid;
  logic        b_err, b_eng_start, b_eng_wr, b_eng_abort, b_eng_wvalid, b_busy;
  logic [7:0]  b_rd_data, b_eng_wdata;
  logic [1:0]  b_eng_cs_sel, b_owner, b_dbg_state;
  logic [23:0] b_eng_addr;
  logic [15:0] b_eng_len;

  int n_tests = 0;
  int n_fail  = 0;
  int nb;
  logic [2:0] exp_rr[4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  int wpat[5] = '{0, 1, 0, 1, 1};

  sram_qpi_arbiter #(.NREQ(3), .ADDR_W(26), .LEN_W(16), .FIXED0(0), .TIMEOUT(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_len(req_len), .gnt(gnt), .done(done), .err(err), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .eng_start(eng_start), .eng_wr(eng_wr), .eng_cs_sel(eng_cs_sel), .eng_addr(eng_addr),
    .eng_len(eng_len), .eng_abort(eng_abort), .eng_wdata(eng_wdata), .eng_wvalid(eng_wvalid),
    .eng_wready(eng_wready), .eng_rdata(eng_rdata), .eng_rvalid(eng_rvalid),
    .eng_done(eng_done), .busy(busy), .owner(owner), .dbg_state(dbg_state)
  );

  sram_qpi_arbiter #(.NREQ(3), .ADDR_W(26), .LEN_W(16), .FIXED0(1), .TIMEOUT(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_len(req_len), .gnt(b_gnt), .done(b_done), .err(b_err), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(b_wr_ready), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .eng_start(b_eng_start), .eng_wr(b_eng_wr), .eng_cs_sel(b_eng_cs_sel), .eng_addr(b_eng_addr),
    .eng_len(b_eng_len), .eng_abort(b_eng_abort), .eng_wdata(b_eng_wdata), .eng_wvalid(b_eng_wvalid),
    .eng_wready(eng_wready), .eng_rdata(eng_rdata), .eng_rvalid(eng_rvalid),
    .eng_done(eng_done), .busy(b_busy), .owner(b_owner), .dbg_state(b_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_cmd(input int k, input logic [25:0] a, input logic [15:0] l);
    req_addr[k*26 +: 26] = a;
    req_len[k*16 +: 16]  = l;
  endtask

  task automatic do_reset();
    req = '0; req_wr = '0; wr_valid = '0; eng_wready = 1'b0;
    eng_rvalid = 1'b0; eng_done = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // reset values
    #2;
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_done", done, 3'b000);
    chk("rst_err", err, 1'b0);
    chk("rst_start", eng_start, 1'b0);
    chk("rst_abort", eng_abort, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", eng_addr, 24'h0);
    chk("rst_len", eng_len, 16'h0);
    chk("rst_owner", owner, 2'd0);
    chk("rst_state", dbg_state, 2'd0);
    do_reset();

    // single read by requester 1
    set_cmd(1, 26'h2000100, 16'd4);
    req = 3'b010;
    step();
    chk("t1_gnt", gnt, 3'b010);
    chk("t1_start", eng_start, 1'b1);
    chk("t1_cs", eng_cs_sel, 2'd2);
    chk("t1_addr", eng_addr, 24'h000100);
    chk("t1_len", eng_len, 16'd4);
    chk("t1_owner", owner, 2'd1);
    chk("t1_wr", eng_wr, 1'b0);
    chk("t1_busy", busy, 1'b1);
    req = 3'b000;
    step();
    chk("t1_start_pulse", eng_start, 1'b0);
    chk("t1_gnt_hold", gnt, 3'b010);
    for (int i = 0; i < 4; i++) begin
      eng_rvalid = 1'b1;
      eng_rdata = 8'(8'hA0 + i);
      #1;
      chk("t1_rd_valid", rd_valid, 3'b010);
      chk("t1_rd_data", rd_data, 8'(8'hA0 + i));
      chk("t1_wr_ready", wr_ready, 3'b000);
      step();
    end
    eng_rvalid = 1'b0;
    eng_done = 1'b1;
    #1;
    chk("t1_no_abort", eng_abort, 1'b0);
    step();
    eng_done = 1'b0;
    chk("t1_done", done, 3'b010);
    chk("t1_err", err, 1'b0);
    chk("t1_gnt_drop", gnt, 3'b000);
    chk("t1_busy_done", busy, 1'b1);
    step();
    chk("t1_done_pulse", done, 3'b000);
    chk("t1_busy_idle", busy, 1'b0);

    // round-robin with all requesting; instance b keeps granting 0
    do_reset();
    set_cmd(0, 26'h0000010, 16'd1);
    set_cmd(1, 26'h1000020, 16'd1);
    set_cmd(2, 26'h3000030, 16'd1);
    req = 3'b111;
    for (int r = 0; r < 4; r++) begin
      step();
      chk("t2_gnt", gnt, exp_rr[r]);
      chk("t3_fixed_gnt", b_gnt, 3'b001);
      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
      chk("t2_done", done, exp_rr[r]);
      chk("t2_gnt_gap", gnt, 3'b000);
      step();
      chk("t2_idle_gnt", gnt, 3'b000);
      chk("t2_idle_busy", busy, 1'b0);
    end
    req = 3'b110;
    for (int r = 0; r < 2; r++) begin
      step();
      chk("t3_rr_gnt", gnt, (r == 0) ? 3'b010 : 3'b100);
      chk("t3_alt_gnt", b_gnt, (r == 0) ? 3'b010 : 3'b100);
      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
      step();
    end

    // write with backpressure by requester 2
    req = 3'b100;
    req_wr = 3'b100;
    wr_valid = 3'b111;
    wr_data = {8'h55, 8'hEE, 8'hDD};
    set_cmd(2, 26'h1000040, 16'd3);
    step();
    req = 3'b000;
    chk("t4_gnt", gnt, 3'b100);
    chk("t4_wr", eng_wr, 1'b1);
    chk("t4_len", eng_len, 16'd3);
    chk("t4_start", eng_start, 1'b1);
    nb = 0;
    for (int c = 0; c < 5; c++) begin
      eng_wready = (wpat[c] != 0);
      eng_rvalid = 1'b1;
      wr_data[23:16] = 8'(8'h55 + nb);
      #1;
      chk("t4_wr_ready", wr_ready, (wpat[c] != 0) ? 3'b100 : 3'b000);
      chk("t4_wvalid", eng_wvalid, 1'b1);
      chk("t4_wdata", eng_wdata, 8'(8'h55 + nb));
      chk("t4_rd_valid", rd_valid, 3'b000);
      if (wpat[c] != 0) nb++;
      step();
    end
    eng_wready = 1'b0;
    eng_rvalid = 1'b0;
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("t4_done", done, 3'b100);
    chk("t4_err", err, 1'b0);
    step();
    req_wr = 3'b000;
    wr_valid = 3'b000;

    // zero length: grant cycle, no start, done next cycle
    set_cmd(0, 26'h0000000, 16'd0);
    req = 3'b001;
    step();
    req = 3'b000;
    chk("t5_z_gnt", gnt, 3'b001);
    chk("t5_z_start", eng_start, 1'b0);
    step();
    chk("t5_z_done", done, 3'b001);
    chk("t5_z_err", err, 1'b0);
    chk("t5_z_gnt_drop", gnt, 3'b000);
    step();
    chk("t5_z_idle", busy, 1'b0);

    // watchdog timeout at RUN cycle 10
    set_cmd(1, 26'h2000000, 16'd5);
    req = 3'b010;
    step();
    req = 3'b000;
    chk("t5_to_gnt", gnt, 3'b010);
    chk("t5_to_start", eng_start, 1'b1);
    chk("t5_to_abort_c1", eng_abort, 1'b0);
    for (int c = 2; c <= 9; c++) begin
      step();
      chk("t5_to_no_abort", eng_abort, 1'b0);
    end
    step();
    chk("t5_to_abort", eng_abort, 1'b1);
    chk("t5_to_gnt_hold", gnt, 3'b010);
    step();
    chk("t5_to_done", done, 3'b010);
    chk("t5_to_err", err, 1'b1);
    chk("t5_to_b_err", b_err, 1'b1);
    chk("t5_to_abort_off", eng_abort, 1'b0);
    step();

    // eng_done coincident with timeout
    set_cmd(2, 26'h3000000, 16'd5);
    req = 3'b100;
    step();
    req = 3'b000;
    chk("t5_co_gnt", gnt, 3'b100);
    repeat (9) step();
    eng_done = 1'b1;
    #1;
    chk("t5_co_no_abort", eng_abort, 1'b0);
    step();
    eng_done = 1'b0;
    chk("t5_co_done", done, 3'b100);
    chk("t5_co_err", err, 1'b0);
    step();

    // reset mid-RUN, then pending request granted from pointer 0
    set_cmd(0, 26'h0000000, 16'd1);
    req = 3'b001;
    step();
    req = 3'b000;
    chk("t6_pre_gnt", gnt, 3'b001);
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    step();
    set_cmd(2, 26'h1000000, 16'd4);
    req = 3'b100;
    step();
    chk("t6_run_gnt", gnt, 3'b100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", gnt, 3'b000);
    chk("t6_rst_start", eng_start, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_owner", owner, 2'd0);
    req = 3'b101;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t6_regrant", gnt, 3'b001);
    chk("t6_owner", owner, 2'd0);
    req = 3'b000;
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
